// File: rtl/micro_mining_pkg.sv
// Shared types and widths for the nonce-search datapath: FSM encoding,
// bus widths and which H_out bytes take part in the target comparison.
package micro_mining_pkg;

  localparam int NONCE_W  = 32;
  localparam int HASH_W   = 24;
  localparam int TARGET_W = 8;

  // Byte 2 is the most significant byte of H_out; bytes 2 and 1 are compared.
  localparam int HASH_BYTE_HI = 2;
  localparam int HASH_BYTE_LO = 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    CHECK = 3'd4,
    DONE  = 3'd5
  } state_t;

  function automatic logic [7:0] hash_byte(input logic [HASH_W-1:0] h, input int idx);
    return h[idx*8 +: 8];
  endfunction

endpackage

// File: rtl/hash_target_cmp.sv
// Difficulty check: a hash passes when both of its upper bytes are strictly
// below the target (unsigned).
module hash_target_cmp
  import micro_mining_pkg::*;
(
  input  logic [HASH_W-1:0]   h_i,
  input  logic [TARGET_W-1:0] target_i,
  output logic                pass_o
);

  logic [7:0] byte_hi;
  logic [7:0] byte_lo;

  assign byte_hi = hash_byte(h_i, HASH_BYTE_HI);
  assign byte_lo = hash_byte(h_i, HASH_BYTE_LO);
  assign pass_o  = (byte_hi < target_i) && (byte_lo < target_i);

endmodule

// File: rtl/nonce_search_ctrl.sv
// Sequencer for the nonce search: issues one capture strobe per nonce, waits
// the hash latency, checks H_out against the target and reports the result.
module nonce_search_ctrl
  import micro_mining_pkg::*;
#(
  parameter int unsigned        HASH_LAT  = 3,
  parameter logic [NONCE_W-1:0] NONCE_MAX = 32'hFFFF_FFFF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [NONCE_W-1:0]  nonce_start,
  input  logic [TARGET_W-1:0] target_in,
  input  logic [HASH_W-1:0]   h_in,
  output logic                selector,
  output logic [NONCE_W-1:0]  nonce,
  output logic [TARGET_W-1:0] target,
  output logic                busy,
  output logic                done,
  output logic                found,
  output logic [NONCE_W-1:0]  nonce_found,
  output state_t              dbg_state
);

  localparam int               CNT_W    = $clog2(HASH_LAT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HASH_LAT - 1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NONCE_W-1:0]   nonce_q, nonce_d;
  logic [TARGET_W-1:0]  target_q, target_d;
  logic                 found_q, found_d;
  logic [NONCE_W-1:0]   nonce_found_q, nonce_found_d;
  logic                 pass;
  logic                 last_attempt;

  hash_target_cmp u_cmp (
    .h_i      (h_in),
    .target_i (target_q),
    .pass_o   (pass)
  );

  // Written as "not below" so a start nonce beyond NONCE_MAX also ends the search.
  assign last_attempt = !(nonce_q < NONCE_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      nonce_q       <= '0;
      target_q      <= '0;
      found_q       <= 1'b0;
      nonce_found_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      nonce_q       <= nonce_d;
      target_q      <= target_d;
      found_q       <= found_d;
      nonce_found_q <= nonce_found_d;
    end
  end

  // Handshake: start is a request taken only while busy is low (IDLE) and abort
  // is low; any start seen while busy is dropped, not queued.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    nonce_d       = nonce_q;
    target_d      = target_q;
    found_d       = found_q;
    nonce_found_d = nonce_found_q;

    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            state_d       = LOAD;
            found_d       = 1'b0;
            nonce_found_d = '0;
          end
        end
        LOAD: begin
          nonce_d  = nonce_start;
          target_d = target_in;
          state_d  = ISSUE;
        end
        ISSUE: begin
          cnt_d   = '0;
          state_d = WAIT;
        end
        WAIT: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = CHECK;
          end
        end
        CHECK: begin
          if (pass) begin
            found_d       = 1'b1;
            nonce_found_d = nonce_q;
            state_d       = DONE;
          end else if (last_attempt) begin
            state_d = DONE;
          end else begin
            nonce_d = nonce_q + NONCE_W'(1);
            state_d = ISSUE;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign selector    = (state_q == ISSUE);
  assign busy        = (state_q == LOAD) || (state_q == ISSUE) ||
                       (state_q == WAIT) || (state_q == CHECK);
  assign done        = (state_q == DONE);
  assign nonce       = nonce_q;
  assign target      = target_q;
  assign found       = found_q;
  assign nonce_found = nonce_found_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_nonce_search_ctrl.sv
// Bench for nonce_search_ctrl: two instances (full nonce range and a range
// ending at 3), a per-instance hash responder and a cycle-level reference model.
module tb_nonce_search_ctrl;
  import micro_mining_pkg::*;

  localparam int          LAT    = 3;
  localparam int          PERIOD = LAT + 2;
  localparam logic [31:0] NMAX_A = 32'hFFFF_FFFF;
  localparam logic [31:0] NMAX_B = 32'h0000_0003;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        start_a = 1'b0, start_b = 1'b0, abort = 1'b0;
  logic [31:0] nonce_start = '0;
  logic [7:0]  target_in = '0;
  logic [23:0] h_a = '0, h_b = '0;
  logic        sel_a, busy_a, done_a, found_a;
  logic        sel_b, busy_b, done_b, found_b;
  logic [31:0] nonce_a, nf_a, nonce_b, nf_b;
  logic [7:0]  target_a, target_b;
  state_t      dbg_state_a, dbg_state_b;

  nonce_search_ctrl #(.HASH_LAT(LAT), .NONCE_MAX(NMAX_A)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .abort(abort),
    .nonce_start(nonce_start), .target_in(target_in), .h_in(h_a),
    .selector(sel_a), .nonce(nonce_a), .target(target_a), .busy(busy_a),
    .done(done_a), .found(found_a), .nonce_found(nf_a), .dbg_state(dbg_state_a)
  );

  nonce_search_ctrl #(.HASH_LAT(LAT), .NONCE_MAX(NMAX_B)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .abort(abort),
    .nonce_start(nonce_start), .target_in(target_in), .h_in(h_b),
    .selector(sel_b), .nonce(nonce_b), .target(target_b), .busy(busy_b),
    .done(done_b), .found(found_b), .nonce_found(nf_b), .dbg_state(dbg_state_b)
  );

  // ---------------- counters / checker ----------------
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- hash responder ----------------
  int hash_mode = 0;

  function automatic logic [23:0] hash_of(input int mode, input logic [31:0] n);
    case (mode)
      2:       hash_of = (n == 32'd7) ? 24'h0505AA : (n == 32'd6) ? 24'h0510AA : 24'h1001AA;
      6:       hash_of = (n == 32'd100) ? 24'h0F0F33 : (n == 32'd101) ? 24'h0E0F55 :
                         (n == 32'd102) ? 24'h0E0E44 : 24'hFFFFFF;
      default: hash_of = 24'h000000;
    endcase
  endfunction

  int          pend_a = 0, pend_b = 0;
  int          sel_cnt_a = 0, sel_cnt_b = 0;
  logic [31:0] cap_a = '0, cap_b = '0;

  always @(negedge clk) begin
    if (!reset) begin
      pend_a <= 0;
    end else if (sel_a) begin
      pend_a    <= LAT;
      cap_a     <= nonce_a;
      h_a       <= 24'hFFFF00;
      sel_cnt_a <= sel_cnt_a + 1;
    end else if (pend_a != 0) begin
      pend_a <= pend_a - 1;
      if (pend_a == 1) h_a <= hash_of(hash_mode, cap_a);
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      pend_b <= 0;
    end else if (sel_b) begin
      pend_b    <= LAT;
      cap_b     <= nonce_b;
      h_b       <= 24'hFFFF00;
      sel_cnt_b <= sel_cnt_b + 1;
    end else if (pend_b != 0) begin
      pend_b <= pend_b - 1;
      if (pend_b == 1) h_b <= hash_of(hash_mode, cap_b);
    end
  end

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        active;
    logic        done_c;
    logic [31:0] t;
    logic [31:0] nonce;
    logic [7:0]  target;
    logic        found;
    logic [31:0] nf;
  } mdl_t;

  // t counts edges since the accepted start; t==0 is the load cycle, then each
  // attempt occupies PERIOD cycles: strobe first, hash judged in the last one.
  function automatic mdl_t mdl_step(input mdl_t m, input logic rst, input logic st,
                                    input logic ab, input logic [31:0] ns,
                                    input logic [7:0] tg, input logic [23:0] h,
                                    input logic [31:0] nmax);
    mdl_t r;
    logic ok;
    r = m;
    if (!rst) begin
      r = '0;
    end else if (m.done_c) begin
      r.done_c = 1'b0;
    end else if (m.active) begin
      if (ab) begin
        r.active = 1'b0;
      end else if (m.t == 0) begin
        r.nonce  = ns;
        r.target = tg;
        r.t      = 1;
      end else if ((m.t - 1) % PERIOD == PERIOD - 1) begin
        ok = (h[23:16] < m.target) && (h[15:8] < m.target);
        if (ok) begin
          r.found  = 1'b1;
          r.nf     = m.nonce;
          r.active = 1'b0;
          r.done_c = 1'b1;
        end else if (m.nonce >= nmax) begin
          r.active = 1'b0;
          r.done_c = 1'b1;
        end else begin
          r.nonce = m.nonce + 1;
          r.t     = m.t + 1;
        end
      end else begin
        r.t = m.t + 1;
      end
    end else if (st && !ab) begin
      r.active = 1'b1;
      r.t      = 0;
      r.found  = 1'b0;
      r.nf     = '0;
    end
    return r;
  endfunction

  logic        s_reset = 1'b0, s_start_a = 1'b0, s_start_b = 1'b0, s_abort = 1'b0;
  logic [31:0] s_ns = '0;
  logic [7:0]  s_tg = '0;
  logic [23:0] s_ha = '0, s_hb = '0;

  always @(posedge clk) begin
    s_reset   <= reset;
    s_start_a <= start_a;
    s_start_b <= start_b;
    s_abort   <= abort;
    s_ns      <= nonce_start;
    s_tg      <= target_in;
    s_ha      <= h_a;
    s_hb      <= h_b;
  end

  task automatic cmp_dut(input string tag, input mdl_t m, input logic sel, input logic bsy,
                         input logic dn, input logic fnd, input logic [31:0] nc,
                         input logic [7:0] tg, input logic [31:0] nf);
    logic exp_sel;
    exp_sel = m.active && (m.t >= 1) && ((m.t - 1) % PERIOD == 0);
    chk({tag, ".selector"},    {31'd0, sel}, {31'd0, exp_sel});
    chk({tag, ".busy"},        {31'd0, bsy}, {31'd0, m.active});
    chk({tag, ".done"},        {31'd0, dn},  {31'd0, m.done_c});
    chk({tag, ".found"},       {31'd0, fnd}, {31'd0, m.found});
    chk({tag, ".nonce"},       nc, m.nonce);
    chk({tag, ".target"},      {24'd0, tg}, {24'd0, m.target});
    chk({tag, ".nonce_found"}, nf, m.nf);
  endtask

  mdl_t ma, mb;

  initial begin
    ma = '0;
    mb = '0;
    forever begin
      @(negedge clk);
      ma = mdl_step(ma, s_reset & reset, s_start_a, s_abort, s_ns, s_tg, s_ha, NMAX_A);
      mb = mdl_step(mb, s_reset & reset, s_start_b, s_abort, s_ns, s_tg, s_hb, NMAX_B);
      cmp_dut("a", ma, sel_a, busy_a, done_a, found_a, nonce_a, target_a, nf_a);
      cmp_dut("b", mb, sel_b, busy_b, done_b, found_b, nonce_b, target_b, nf_b);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic launch(input bit which, input logic [31:0] ns, input logic [7:0] tg);
    nonce_start = ns;
    target_in   = tg;
    if (which) start_b = 1'b1;
    else start_a = 1'b1;
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // Returns the number of edges from the start-sampling edge to the done cycle.
  task automatic wait_done(input bit which, input int budget, output int cyc);
    bit seen;
    cyc  = 0;
    seen = 1'b0;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk);
      #1;
      if ((which ? done_b : done_a) === 1'b1) begin
        cyc  = i;
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int cyc;
    int sel0;
    int dcount;

    tick();
    tick();
    reset = 1'b1;
    tick();

    // Reset during the first wait phase
    hash_mode = 2;
    launch(1'b0, 32'd5, 8'h10);
    tick();
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst.busy",   {31'd0, busy_a}, 32'd0);
    chk("rst.nonce",  nonce_a, 32'd0);
    chk("rst.target", {24'd0, target_a}, 32'd0);
    chk("rst.state",  {29'd0, dbg_state_a}, {29'd0, IDLE});
    @(posedge clk);
    #2;
    reset = 1'b1;
    tick();

    // Hit at nonce 7 from 5
    sel0 = sel_cnt_a;
    launch(1'b0, 32'd5, 8'h10);
    wait_done(1'b0, 40, cyc);
    chk("hit.cycles", cyc, 32'd16);
    chk("hit.found", {31'd0, found_a}, 32'd1);
    chk("hit.nonce_found", nf_a, 32'd7);
    chk("hit.strobes", sel_cnt_a - sel0, 32'd3);
    tick();
    tick();

    // Abort during the second wait phase
    launch(1'b0, 32'd5, 8'h10);
    repeat (8) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort.busy",  {31'd0, busy_a}, 32'd0);
    chk("abort.found", {31'd0, found_a}, 32'd0);
    chk("abort.nonce", nonce_a, 32'd6);
    dcount = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done_a) dcount++;
    end
    chk("abort.no_done", dcount, 32'd0);

    // Start while busy is ignored
    launch(1'b0, 32'd5, 8'h10);
    tick();
    tick();
    nonce_start = 32'h50;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    wait_done(1'b0, 40, cyc);
    chk("busy_start.cycles", cyc, 32'd13);
    chk("busy_start.nonce_found", nf_a, 32'd7);
    tick();
    // start together with abort in IDLE
    start_a = 1'b1;
    abort = 1'b1;
    tick();
    start_a = 1'b0;
    abort = 1'b0;
    chk("start_abort.busy", {31'd0, busy_a}, 32'd0);
    tick();
    chk("start_abort.busy2", {31'd0, busy_a}, 32'd0);
    chk("start_abort.found_held", {31'd0, found_a}, 32'd1);

    // Compare boundary: equal bytes fail, one byte equal fails, both below pass
    hash_mode = 6;
    launch(1'b0, 32'd100, 8'h0F);
    wait_done(1'b0, 40, cyc);
    chk("bound.cycles", cyc, 32'd16);
    chk("bound.nonce_found", nf_a, 32'd102);
    tick();

    // Exhaust with target 0 on the short range
    hash_mode = 3;
    sel0 = sel_cnt_b;
    launch(1'b1, 32'd0, 8'h00);
    wait_done(1'b1, 60, cyc);
    chk("exh.cycles", cyc, 32'd21);
    chk("exh.found", {31'd0, found_b}, 32'd0);
    chk("exh.nonce", nonce_b, 32'd3);
    chk("exh.strobes", sel_cnt_b - sel0, 32'd4);
    tick();
    tick();
    chk("exh.nonce_hold", nonce_b, 32'd3);

    // Start beyond the range: single failing attempt
    hash_mode = 2;
    launch(1'b1, 32'd9, 8'h10);
    wait_done(1'b1, 30, cyc);
    chk("over.cycles", cyc, 32'd6);
    chk("over.nonce", nonce_b, 32'd9);
    tick();

    // Start exactly at the last nonce: single passing attempt
    hash_mode = 7;
    launch(1'b1, 32'd3, 8'h01);
    wait_done(1'b1, 30, cyc);
    chk("last.cycles", cyc, 32'd6);
    chk("last.found", {31'd0, found_b}, 32'd1);
    chk("last.nonce_found", nf_b, 32'd3);

    repeat (4) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
